// File: rtl/accel_bram_master.sv
// Command-driven initiator for a BRAM-controller port: streams write bursts onto the port, or issues
// reads and returns the data in order through a small credit-guarded first-word-fall-through FIFO.
module accel_bram_master #(
    parameter int ADDR_W     = 22,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 16,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr_a,
    output logic [DATA_W-1:0] wrdata_a,
    input  logic [DATA_W-1:0] rddata_a,
    output logic              en_a,
    output logic [3:0]        we_a,
    output logic              rst_a
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t            state, next_state;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  remaining;
    logic              cmd_fire, wr_fire, rd_issue, rd_on_port, push, pop;
    logic [RD_LAT-1:0] rd_sr;
    logic [CNT_W-1:0]  inflight, fifo_count;
    logic [SUM_W-1:0]  credit_used;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

    // All three streams (cmd, wr, rd) transfer exactly on a cycle where valid and ready are both high;
    // valid never waits on ready, and ready here depends only on registered state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (cmd_fire) begin
                    if (cmd_len == '0)  next_state = S_FIN;
                    else if (cmd_write) next_state = S_WRITE;
                    else                next_state = S_READ;
                end
            end
            S_WRITE: if (wr_fire && remaining == LEN_W'(1))  next_state = S_FIN;
            S_READ:  if (rd_issue && remaining == LEN_W'(1)) next_state = S_DRAIN;
            S_DRAIN: if (inflight == '0 && fifo_count == '0) next_state = S_FIN;
            S_FIN:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready   = (state == S_IDLE);
        wr_ready    = (state == S_WRITE);
        busy        = (state != S_IDLE);
        done        = (state == S_FIN);
        cmd_fire    = cmd_valid & cmd_ready;
        wr_fire     = wr_valid & wr_ready;
        // A read may only go out if its return slot is already guaranteed in the FIFO.
        credit_used = SUM_W'(fifo_count) + SUM_W'(inflight);
        rd_issue    = (state == S_READ) && (remaining != '0) && (credit_used < SUM_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr  <= '0;
            remaining <= '0;
        end else if (cmd_fire) begin
            cur_addr  <= cmd_addr & ~ADDR_W'(3);
            remaining <= cmd_len;
        end else if (wr_fire || rd_issue) begin
            cur_addr  <= cur_addr + ADDR_W'(4);
            remaining <= remaining - LEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_a     <= 1'b0;
            we_a     <= 4'h0;
            addr_a   <= '0;
            wrdata_a <= '0;
        end else if (wr_fire) begin
            en_a     <= 1'b1;
            we_a     <= 4'hF;
            addr_a   <= cur_addr;
            wrdata_a <= wr_data;
        end else if (rd_issue) begin
            en_a     <= 1'b1;
            we_a     <= 4'h0;
            addr_a   <= cur_addr;
            wrdata_a <= '0;
        end else begin
            en_a     <= 1'b0;
            we_a     <= 4'h0;
            wrdata_a <= '0;
        end
    end

    assign rd_on_port = en_a & (we_a == 4'h0);
    assign push       = rd_sr[RD_LAT-1];
    assign pop        = rd_valid & rd_ready;

    // rd_sr[i] marks that the read on the port i+1 cycles ago has data on rddata_a in its last stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sr    <= '0;
            inflight <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) rd_sr[i] <= rd_sr[i-1];
            rd_sr[0] <= rd_on_port;
            inflight <= inflight + CNT_W'(rd_issue) - CNT_W'(push);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= rddata_a;
    end

    assign rd_valid = (fifo_count != '0);
    assign rd_data  = fifo_mem[rd_ptr];
    assign rst_a    = 1'b0;
endmodule

// File: tb/tb_accel_bram_master.sv
// Bench for accel_bram_master: two instances (RD_LAT=1 and RD_LAT=2) share one stimulus stream, each
// with its own BRAM model, checked against a command-level memory model through expected queues.
module tb_accel_bram_master;
    localparam int NI = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        cmd_valid, cmd_write;
    logic [21:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        wr_valid, rd_ready;
    logic [31:0] wr_data;

    logic [NI-1:0] cmd_ready, wr_ready, rd_valid, busy, done, en_a, rst_a;
    logic [31:0]   rd_data  [NI];
    logic [21:0]   addr_a   [NI];
    logic [31:0]   wrdata_a [NI];
    logic [3:0]    we_a     [NI];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [21:0] exp_wr_a [$];
    logic [31:0] exp_wr_d [$];
    logic [21:0] exp_ra   [$];
    logic [31:0] exp_q    [$];
    logic [31:0] ref_mem  [logic [21:0]];
    logic [31:0] wr_stream [$];

    int wr_idx [NI];
    int ra_idx [NI];
    int rd_idx [NI];
    int done_cnt [NI];
    int done_time [NI];
    logic cur_write = 1'b0;
    int   cur_len = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [21:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : {10'b0, a};
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int RDL = g + 1;
        logic [31:0] rdd;
        logic [31:0] bram [logic [21:0]];
        logic [31:0] pipe [RDL];

        function automatic logic [31:0] bram_rd(input logic [21:0] a);
            return bram.exists(a) ? bram[a] : {10'b0, a};
        endfunction

        always @(posedge clk) begin
            if (en_a[g] && we_a[g] == 4'hF) bram[addr_a[g]] = wrdata_a[g];
            pipe[0] <= (en_a[g] && we_a[g] == 4'h0) ? bram_rd(addr_a[g]) : 32'hDEAD_BEEF;
            for (int i = 1; i < RDL; i++) pipe[i] <= pipe[i-1];
        end
        assign rdd = pipe[RDL-1];

        accel_bram_master #(
            .ADDR_W(22), .DATA_W(32), .LEN_W(16), .RD_LAT(RDL), .FIFO_DEPTH(4)
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[g]), .cmd_write(cmd_write),
            .cmd_addr(cmd_addr), .cmd_len(cmd_len),
            .wr_valid(wr_valid), .wr_ready(wr_ready[g]), .wr_data(wr_data),
            .rd_valid(rd_valid[g]), .rd_ready(rd_ready), .rd_data(rd_data[g]),
            .busy(busy[g]), .done(done[g]),
            .addr_a(addr_a[g]), .wrdata_a(wrdata_a[g]), .rddata_a(rdd),
            .en_a(en_a[g]), .we_a(we_a[g]), .rst_a(rst_a[g])
        );
    end

    // Scoreboard monitor: pops expectations as each DUT presents port accesses and read beats.
    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (!rst_n) begin
                wr_idx[g] = exp_wr_a.size();
                ra_idx[g] = exp_ra.size();
                rd_idx[g] = exp_q.size();
            end else begin
                if (en_a[g]) begin
                    if (we_a[g] == 4'hF) begin
                        if (wr_idx[g] < exp_wr_a.size()) begin
                            check("port_wr_addr", addr_a[g], exp_wr_a[wr_idx[g]]);
                            check("port_wr_data", wrdata_a[g], exp_wr_d[wr_idx[g]]);
                        end else check("port_wr_extra", wr_idx[g] + 1, exp_wr_a.size());
                        wr_idx[g]++;
                    end else if (we_a[g] == 4'h0) begin
                        if (ra_idx[g] < exp_ra.size())
                            check("port_rd_addr", addr_a[g], exp_ra[ra_idx[g]]);
                        else check("port_rd_extra", ra_idx[g] + 1, exp_ra.size());
                        ra_idx[g]++;
                    end else check("port_we_a", we_a[g], 4'hF);
                end
                if (rd_valid[g] && rd_ready) begin
                    if (rd_idx[g] < exp_q.size())
                        check("rd_data", rd_data[g], exp_q[rd_idx[g]]);
                    else check("rd_extra_beat", rd_idx[g] + 1, exp_q.size());
                    rd_idx[g]++;
                end
                if (done[g]) begin
                    done_cnt[g]++;
                    done_time[g] = cyc;
                    if (cur_write && cur_len != 0) begin
                        check("done_with_last_wr", {en_a[g], we_a[g]}, 5'h1F);
                        check("done_wr_all", wr_idx[g], exp_wr_a.size());
                    end else if (!cur_write) begin
                        check("done_rd_all", rd_idx[g], exp_q.size());
                        check("done_fifo_empty", rd_valid[g], 0);
                    end
                end
            end
        end
    end

    task automatic push_exp(input bit wr, input logic [21:0] addr, input int len,
                            input logic [31:0] dbase);
        logic [21:0] a;
        wr_stream = {};
        for (int i = 0; i < len; i++) begin
            a = (addr & ~22'h3) + 22'(4 * i);
            if (wr) begin
                wr_stream.push_back(dbase != 0 ? dbase + 32'(i) : $urandom);
                exp_wr_a.push_back(a);
                exp_wr_d.push_back(wr_stream[i]);
                ref_mem[a] = wr_stream[i];
            end else begin
                exp_ra.push_back(a);
                exp_q.push_back(ref_word(a));
            end
        end
        cur_write = wr;
        cur_len = len;
    endtask

    task automatic issue_cmd(input bit wr, input logic [21:0] addr, input int len);
        int n = 0;
        while (cmd_ready != 2'b11 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("cmd_ready_wait", n < 100, 1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr = addr;
        cmd_len = 16'(len);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr = 22'($urandom);
        cmd_len = 16'($urandom);
    endtask

    // wmode: 0 always valid, 1 alternate, 2 random. rmode: 0 always ready, 1 stall 20 cycles, 2 random.
    task automatic run_cmd(input bit wr, input logic [21:0] addr, input int len,
                           input int wmode, input int rmode, input logic [31:0] dbase);
        int k = 0;
        int acc_cyc;
        int d0 [NI];
        int ra0 [NI];
        bit ok = 0;
        push_exp(wr, addr, len, dbase);
        for (int g = 0; g < NI; g++) d0[g] = done_cnt[g];
        issue_cmd(wr, addr, len);
        acc_cyc = cyc;
        for (int g = 0; g < NI; g++) ra0[g] = ra_idx[g];
        for (int n = 0; n < 2000; n++) begin
            if (wr) begin
                wr_valid = (k < len) && (wmode == 0 || (wmode == 1 && n % 2 == 0) ||
                                         (wmode == 2 && $urandom_range(0, 1) == 1));
                wr_data = (k < len) ? wr_stream[k] : $urandom;
            end
            rd_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (n >= 20) : 1'($urandom_range(0, 1));
            if (rmode == 1 && n == 20)
                for (int g = 0; g < NI; g++)
                    check("stall_issue_count", ra_idx[g] - ra0[g], (len < 4) ? len : 4);
            @(negedge clk);
            if (wr_valid && wr_ready == 2'b11) k++;
            if (busy == 2'b00) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        check("cmd_complete", ok, 1);
        for (int g = 0; g < NI; g++) begin
            check("done_count", done_cnt[g] - d0[g], 1);
            check("wr_beats", wr_idx[g], exp_wr_a.size());
            check("rd_addrs", ra_idx[g], exp_ra.size());
            check("rd_words", rd_idx[g], exp_q.size());
            if (len == 0) check("zero_len_done_lat", (done_time[g] - acc_cyc) <= 1, 1);
        end
    endtask

    task automatic reset_checks();
        for (int g = 0; g < NI; g++) begin
            check("rst_en_a", en_a[g], 0);
            check("rst_we_a", we_a[g], 0);
            check("rst_addr_a", addr_a[g], 0);
            check("rst_wrdata_a", wrdata_a[g], 0);
            check("rst_rd_valid", rd_valid[g], 0);
            check("rst_wr_ready", wr_ready[g], 0);
            check("rst_done", done[g], 0);
            check("rst_busy", busy[g], 0);
            check("rst_cmd_ready", cmd_ready[g], 1);
            check("rst_a_tied", rst_a[g], 0);
        end
    endtask

    task automatic abort_read();
        int d0 [NI];
        push_exp(0, 22'h000200, 8, 0);
        for (int g = 0; g < NI; g++) d0[g] = done_cnt[g];
        rd_ready = 1'b0;
        issue_cmd(0, 22'h000200, 8);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        reset_checks();
        for (int g = 0; g < NI; g++) check("abort_no_done", done_cnt[g], d0[g]);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        rd_ready = 1'b1;
        @(posedge clk); #1;
        for (int g = 0; g < NI; g++) check("post_abort_rd_valid", rd_valid[g], 0);
    endtask

    initial begin
        logic [21:0] ra;
        bit rw;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr = '0;
        cmd_len = '0;
        wr_valid = 1'b0;
        wr_data = '0;
        rd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_checks();
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_cmd(1, 22'h000100, 3, 0, 0, 32'hA);
        run_cmd(0, 22'h000101, 3, 0, 2, 0);
        run_cmd(0, 22'h3FFFF8, 8, 0, 0, 0);
        run_cmd(0, 22'h3FFFF8, 8, 0, 1, 0);
        run_cmd(0, 22'h000040, 0, 0, 0, 0);
        run_cmd(1, 22'h000044, 0, 0, 0, 0);
        run_cmd(1, 22'h000200, 4, 1, 0, 0);
        run_cmd(0, 22'h000200, 4, 0, 2, 0);
        run_cmd(1, 22'h000300, 2, 0, 0, 0);
        abort_read();
        run_cmd(1, 22'h000300, 2, 2, 0, 0);
        run_cmd(0, 22'h000300, 2, 0, 0, 0);

        for (int t = 0; t < 14; t++) begin
            rw = 1'($urandom_range(0, 1));
            ra = 22'(($urandom_range(0, 1) == 1 ? 32'h3FFFC0 : 32'h0) +
                     32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3)));
            run_cmd(rw, ra, $urandom_range(0, 10), $urandom_range(0, 2),
                    2 * $urandom_range(0, 1), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
